// File: rtl/hc595_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hc595_ctrl
// Purpose  : Serialises one display frame {sel[5:0], seg[7:0]} MSB first into
//            two cascaded 74HC595 shift registers, then pulses the storage
//            clock so the new frame appears on the tube in one step.
//            A one-deep, latest-wins pending buffer lets producers issue start
//            at any rate without ever tearing a frame in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   sel        in   6  digit select (1 = digit on), sampled on accepted start
//   seg        in   8  segment code (active low, bit 7 = dp)
//   start      in   1  one-cycle frame request
//   busy       out  1  high while a frame is shifting or latching
//   done       out  1  one-cycle pulse when a frame reaches the 595 outputs
//   ds         out  1  595 serial data
//   shcp       out  1  595 shift clock
//   stcp       out  1  595 storage clock
//   oe         out  1  595 output enable (active low), 0 after first frame
// Parameters
//   DIV        sys_clk cycles per serial bit (even, >= 2)
//   LATCH_CYC  sys_clk cycles spent latching (>= 2)
// ============================================================================
module hc595_ctrl #(
  parameter int DIV       = 4,
  parameter int LATCH_CYC = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe
);

  localparam int PH_W = $clog2(DIV);
  localparam int LC_W = $clog2(LATCH_CYC);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(DIV / 2);
  localparam logic [LC_W-1:0] LC_LAST   = LC_W'(LATCH_CYC - 1);
  localparam logic [LC_W-1:0] LC_HALF   = LC_W'(LATCH_CYC / 2);
  localparam logic [3:0]      BIT_FIRST = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t            state,     state_nxt;
  logic [PH_W-1:0]   phase,     phase_nxt;
  logic [3:0]        bit_idx,   bit_nxt;
  logic [LC_W-1:0]   lcnt,      lcnt_nxt;
  logic [13:0]       word,      word_nxt;
  logic              pend,      pend_nxt;
  logic [13:0]       pend_word, pend_word_nxt;

  logic              done_nxt;
  logic              busy_nxt;
  logic              ds_nxt;
  logic              shcp_nxt;
  logic              stcp_nxt;
  logic              oe_nxt;

  logic [13:0]       frame_in;

  assign frame_in = {sel, seg};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    bit_nxt       = bit_idx;
    lcnt_nxt      = lcnt;
    word_nxt      = word;
    pend_nxt      = pend;
    pend_word_nxt = pend_word;
    done_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          word_nxt  = frame_in;
          state_nxt = SHIFT;
          bit_nxt   = BIT_FIRST;
          phase_nxt = '0;
        end
      end

      SHIFT: begin
        // Any start while busy lands in the pending slot; the frame being
        // shifted is never touched.
        if (start) begin
          pend_word_nxt = frame_in;
          pend_nxt      = 1'b1;
        end
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          if (bit_idx == 4'd0) begin
            state_nxt = LATCH;
            lcnt_nxt  = '0;
          end else begin
            bit_nxt = bit_idx - 4'd1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end

      LATCH: begin
        if (lcnt == LC_LAST) begin
          done_nxt = 1'b1;
          lcnt_nxt = '0;
          if (pend) begin
            // Drain the pending frame; a start on this very edge refills
            // the slot so it is never lost.
            word_nxt  = pend_word;
            state_nxt = SHIFT;
            bit_nxt   = BIT_FIRST;
            phase_nxt = '0;
            pend_nxt  = start;
            if (start) begin
              pend_word_nxt = frame_in;
            end
          end else if (start) begin
            // Nothing pending: take the new frame straight away so busy
            // stays high without a gap.
            word_nxt  = frame_in;
            state_nxt = SHIFT;
            bit_nxt   = BIT_FIRST;
            phase_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          lcnt_nxt = lcnt + 1'b1;
          if (start) begin
            pend_word_nxt = frame_in;
            pend_nxt      = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output next values are decoded from the next state so that every pin is
  // a plain flop output: no decode glitches reach the 595s and the pins are
  // valid in the same cycle the FSM enters the matching state.
  // --------------------------------------------------------------------------
  always_comb begin
    ds_nxt   = ds;
    shcp_nxt = 1'b0;
    stcp_nxt = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    oe_nxt   = done_nxt ? 1'b0 : oe;

    if (state_nxt == SHIFT) begin
      ds_nxt   = word_nxt[bit_nxt];
      shcp_nxt = (phase_nxt >= PH_HALF);
    end
    if (state_nxt == LATCH) begin
      stcp_nxt = (lcnt_nxt >= LC_HALF);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      bit_idx   <= '0;
      lcnt      <= '0;
      word      <= '0;
      pend      <= 1'b0;
      pend_word <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ds        <= 1'b0;
      shcp      <= 1'b0;
      stcp      <= 1'b0;
      oe        <= 1'b1;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      bit_idx   <= bit_nxt;
      lcnt      <= lcnt_nxt;
      word      <= word_nxt;
      pend      <= pend_nxt;
      pend_word <= pend_word_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ds        <= ds_nxt;
      shcp      <= shcp_nxt;
      stcp      <= stcp_nxt;
      oe        <= oe_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hc595_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hc595_ctrl
// Purpose  : Self-checking bench for hc595_ctrl. A frame-level reference
//            model predicts every output pin per cycle from the frame start
//            edges; a 74HC595 pair model reconstructs the latched word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_ctrl;

  localparam int DIV       = 4;
  localparam int LATCH_CYC = 4;
  localparam int SHIFT_CYC = 14 * DIV;
  localparam int FRAME     = SHIFT_CYC + LATCH_CYC;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       start;
  logic       busy, done, ds, shcp, stcp, oe;

  hc595_ctrl #(.DIV(DIV), .LATCH_CYC(LATCH_CYC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sel       (sel),
    .seg       (seg),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ds        (ds),
    .shcp      (shcp),
    .stcp      (stcp),
    .oe        (oe)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge counter and inputs as seen by the DUT on each rising edge.
  int          cyc = 0;
  logic        smp_start = 1'b0;
  logic        smp_rst   = 1'b0;
  logic [13:0] smp_frame = '0;

  always @(posedge sys_clk) begin
    cyc       <= cyc + 1;
    smp_start <= start;
    smp_rst   <= sys_rst_n;
    smp_frame <= {sel, seg};
  end

  // --------------------------------------------------------------------------
  // 74HC595 pair model
  // --------------------------------------------------------------------------
  logic [13:0] sr = '0;
  logic [13:0] q595 = '0;
  int          shcp_edges = 0;
  int          shcp_cnt = 0;
  logic        cap_en = 1'b0;
  logic [13:0] ds_cap = '0;

  initial forever begin
    @(posedge shcp or negedge sys_rst_n);
    if (!sys_rst_n) begin
      shcp_cnt = 0;
    end else if (shcp) begin
      sr = {sr[12:0], ds};
      shcp_cnt++;
      shcp_edges++;
      if (cap_en) ds_cap = {ds_cap[12:0], ds};
    end
  end

  int stcp_edges = 0;
  int shcp_mark  = 0;

  initial forever begin
    @(posedge stcp or negedge sys_rst_n);
    if (!sys_rst_n) begin
      shcp_mark = 0;
    end else if (stcp) begin
      q595 = sr;
      stcp_edges++;
      chk("shcp_per_latch", shcp_cnt - shcp_mark, 14);
      shcp_mark = shcp_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Frame-level reference model and per-cycle output check
  // --------------------------------------------------------------------------
  int          busy_total = 0;
  int          done_total = 0;
  logic [13:0] done_log[$];
  int          done_edges[$];

  initial begin
    logic        m_inflight, m_pend, m_last_ds, m_oe, e_done;
    logic        e_ds, e_shcp, e_stcp;
    logic [13:0] m_word, m_pend_word, done_word;
    int          m_start, t, k;
    m_inflight = 0; m_pend = 0; m_last_ds = 0; m_oe = 1;
    m_word = '0; m_pend_word = '0; done_word = '0; m_start = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n || !smp_rst) begin
        m_inflight = 0; m_pend = 0; m_last_ds = 0; m_oe = 1;
        chk("reset_outputs", {26'd0, busy, done, ds, shcp, stcp, oe}, 32'd1);
      end else begin
        t = cyc;
        e_done = 0;
        if (m_inflight && t == m_start + FRAME) begin
          e_done     = 1;
          done_word  = m_word;
          m_inflight = 0;
          m_last_ds  = m_word[0];
          m_oe       = 0;
          if (m_pend) begin
            m_inflight = 1; m_start = t; m_word = m_pend_word; m_pend = 0;
          end
        end
        if (smp_start) begin
          if (!m_inflight) begin
            m_inflight = 1; m_start = t; m_word = smp_frame;
          end else begin
            m_pend = 1; m_pend_word = smp_frame;
          end
        end
        e_ds = m_last_ds; e_shcp = 0; e_stcp = 0;
        if (m_inflight) begin
          k = t - m_start;
          if (k < SHIFT_CYC) begin
            e_ds   = m_word[13 - k / DIV];
            e_shcp = (k % DIV) >= DIV / 2;
          end else begin
            e_ds   = m_word[0];
            e_stcp = (k - SHIFT_CYC) >= LATCH_CYC / 2;
          end
        end
        if (busy) busy_total++;
        chk("cycle_outputs", {26'd0, busy, done, ds, shcp, stcp, oe},
            {26'd0, m_inflight, e_done, e_ds, e_shcp, e_stcp, m_oe});
        if (e_done) chk("latched_word", {18'd0, q595}, {18'd0, done_word});
        if (done) begin
          done_log.push_back(q595);
          done_edges.push_back(t);
          done_total++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge)
  // --------------------------------------------------------------------------
  task automatic start_at(input int e, input logic [13:0] f);
    while (cyc < e - 1) @(negedge sys_clk);
    {sel, seg} = f;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    {sel, seg} = 14'($urandom);
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while (done_total < n && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    @(negedge sys_clk);
    chk("done_wait", {31'd0, done_total >= n}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          e, n0, b0, se, st;
    logic [13:0] fa, fb, fc;
    sys_rst_n = 1'b0;
    start = 1'b0;
    {sel, seg} = '0;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;

    // Idle after reset: nothing moves.
    repeat (20) @(negedge sys_clk);
    chk("idle_shcp_edges", shcp_edges, 0);
    chk("idle_stcp_edges", stcp_edges, 0);

    // Single frame {3F, C0}.
    n0 = done_total; b0 = busy_total;
    cap_en = 1'b1;
    e = cyc + 2;
    start_at(e, {6'b111111, 8'hC0});
    wait_done(n0 + 1, 200);
    cap_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("ds_bit_sequence", {18'd0, ds_cap}, {18'd0, 14'b11111111000000});
    chk("single_latched", {18'd0, done_log[n0]}, {18'd0, 14'h3FC0});
    chk("single_done_latency", done_edges[n0] - e, 60);
    chk("single_busy_cycles", busy_total - b0, 60);
    chk("single_stcp_pulses", stcp_edges, 1);
    chk("oe_after_first", {31'd0, oe}, 32'd0);

    // Frame {01, F9}.
    n0 = done_total;
    start_at(cyc + 3, {6'b000001, 8'hF9});
    wait_done(n0 + 1, 200);
    chk("frame_f9", {18'd0, done_log[n0]}, {18'd0, 14'b000001_11111001});

    // Three starts during one frame: original then latest only.
    repeat (5) @(negedge sys_clk);
    n0 = done_total; b0 = busy_total;
    fa = 14'($urandom); fb = 14'($urandom); fc = 14'($urandom);
    e = cyc + 2;
    start_at(e, fa);
    start_at(e + 5 + int'($urandom_range(0, 9)), fb);
    start_at(e + 20 + int'($urandom_range(0, 9)), {6'($urandom), 8'($urandom)});
    start_at(e + 40 + int'($urandom_range(0, 14)), fc);
    wait_done(n0 + 2, 300);
    repeat (5) @(negedge sys_clk);
    chk("overwrite_count", done_total - n0, 2);
    chk("overwrite_first", {18'd0, done_log[n0]}, {18'd0, fa});
    chk("overwrite_second", {18'd0, done_log[n0 + 1]}, {18'd0, fc});
    chk("overwrite_gap", done_edges[n0 + 1] - done_edges[n0], 60);
    chk("overwrite_busy", busy_total - b0, 120);

    // Start on the done edge with nothing pending: no busy gap.
    repeat (5) @(negedge sys_clk);
    n0 = done_total; b0 = busy_total;
    fa = 14'($urandom); fb = 14'($urandom);
    e = cyc + 2;
    start_at(e, fa);
    start_at(e + FRAME, fb);
    wait_done(n0 + 2, 300);
    repeat (5) @(negedge sys_clk);
    chk("coincident_second", {18'd0, done_log[n0 + 1]}, {18'd0, fb});
    chk("coincident_done2", done_edges[n0 + 1] - e, 120);
    chk("coincident_busy", busy_total - b0, 120);

    // Start on the done edge while a frame is pending: both survive.
    repeat (5) @(negedge sys_clk);
    n0 = done_total;
    fa = 14'($urandom); fb = 14'($urandom); fc = 14'($urandom);
    e = cyc + 2;
    start_at(e, fa);
    start_at(e + 10, fb);
    start_at(e + FRAME, fc);
    wait_done(n0 + 3, 400);
    chk("pend_coinc_b", {18'd0, done_log[n0 + 1]}, {18'd0, fb});
    chk("pend_coinc_c", {18'd0, done_log[n0 + 2]}, {18'd0, fc});
    chk("pend_coinc_done3", done_edges[n0 + 2] - e, 180);

    // Reset during bit 7 with a pending frame.
    repeat (5) @(negedge sys_clk);
    e = cyc + 2;
    start_at(e, 14'($urandom));
    start_at(e + 3, 14'($urandom));
    while (cyc < e + 24) @(negedge sys_clk);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 chk("async_reset_outputs", {26'd0, busy, done, ds, shcp, stcp, oe}, 32'd1);
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    n0 = done_total; se = shcp_edges; st = stcp_edges;
    repeat (200) @(negedge sys_clk);
    chk("post_reset_shcp", shcp_edges - se, 0);
    chk("post_reset_stcp", stcp_edges - st, 0);
    chk("post_reset_done", done_total - n0, 0);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 8; i++) begin
      e = cyc + 1 + int'($urandom_range(0, 70));
      start_at(e, 14'($urandom));
      if ($urandom_range(0, 1) == 1)
        start_at(e + int'($urandom_range(1, 70)), 14'($urandom));
    end
    repeat (250) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
